// File: rtl/pc_sel_ctrl.sv
// Next-PC sequencing controller.
// Selects the PC mux source every cycle and owns the machine trap state.
// The trap state covers MEPC, MCAUSE and the in-handler flag.
// After any redirect it holds the pipeline flush for FLUSH_CYCLES cycles.
// It parks the core in HALT on a double fault.
module pc_sel_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CAUSE_W      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [31:0]        pc_cur,
    input  logic               branch_taken,
    input  logic               jal,
    input  logic               jalr,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic               irq,
    input  logic               irq_en,
    input  logic               mret,
    output logic [2:0]         Control_PC_Mux,
    output logic [31:0]        mepc,
    output logic [31:0]        mcause,
    output logic               flush,
    output logic               in_handler,
    output logic               halted
);

    localparam logic [2:0] SEL_PC4    = 3'b000;
    localparam logic [2:0] SEL_BRANCH = 3'b001;
    localparam logic [2:0] SEL_JAL    = 3'b011;
    localparam logic [2:0] SEL_JALR   = 3'b100;
    localparam logic [2:0] SEL_TRAP   = 3'b101;
    localparam logic [2:0] SEL_MRET   = 3'b111;

    localparam logic [CAUSE_W-1:0] CAUSE_IRQ     = CAUSE_W'(11);
    localparam logic [CAUSE_W-1:0] CAUSE_ILL_RET = CAUSE_W'(2);
    localparam logic [2:0]         FLUSH_LOAD    = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mepc_d, mcause_d;
    logic        flush_d, in_handler_d, halted_d;

    // Trap request decoded in RUN; an illegal mret is folded in as cause 2.
    logic               irq_take;
    logic               trap_go;
    logic               trap_irq;
    logic [CAUSE_W-1:0] trap_cause;

    // Next-state, mux select and next values of the trap registers.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mepc_d         = mepc;
        mcause_d       = mcause;
        flush_d        = flush;
        in_handler_d   = in_handler;
        halted_d       = halted;
        Control_PC_Mux = SEL_PC4;
        irq_take       = irq && irq_en && !in_handler;
        trap_go        = 1'b0;
        trap_irq       = 1'b0;
        trap_cause     = '0;

        if (!stall) begin
            unique case (state_q)
                ST_RUN: begin
                    if (exc_req) begin
                        if (in_handler) begin
                            // Fault inside the handler: stop the core for good.
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                            flush_d  = 1'b1;
                        end else begin
                            trap_go    = 1'b1;
                            trap_cause = exc_cause;
                        end
                    end else if (irq_take) begin
                        trap_go    = 1'b1;
                        trap_irq   = 1'b1;
                        trap_cause = CAUSE_IRQ;
                    end else if (mret && !in_handler) begin
                        trap_go    = 1'b1;
                        trap_cause = CAUSE_ILL_RET;
                    end else if (mret) begin
                        Control_PC_Mux = SEL_MRET;
                        in_handler_d   = 1'b0;
                        state_d        = ST_FLUSH;
                    end else if (jalr) begin
                        Control_PC_Mux = SEL_JALR;
                        state_d        = ST_FLUSH;
                    end else if (jal) begin
                        Control_PC_Mux = SEL_JAL;
                        state_d        = ST_FLUSH;
                    end else if (branch_taken) begin
                        Control_PC_Mux = SEL_BRANCH;
                        state_d        = ST_FLUSH;
                    end

                    if (trap_go) begin
                        Control_PC_Mux = SEL_TRAP;
                        mepc_d         = pc_cur;
                        mcause_d       = '0;
                        mcause_d[31]   = trap_irq;
                        mcause_d[CAUSE_W-1:0] = trap_cause;
                        in_handler_d   = 1'b1;
                        state_d        = ST_FLUSH;
                    end

                    if (state_d == ST_FLUSH) begin
                        cnt_d   = FLUSH_LOAD;
                        flush_d = 1'b1;
                    end
                end

                ST_FLUSH: begin
                    // Younger instructions are being squashed: ignore their requests.
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                ST_HALT: begin
                    // Sticky until reset.
                end

                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    // State, flush counter and registered trap outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= 3'd0;
            mepc       <= 32'd0;
            mcause     <= 32'd0;
            flush      <= 1'b0;
            in_handler <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mepc       <= mepc_d;
            mcause     <= mcause_d;
            flush      <= flush_d;
            in_handler <= in_handler_d;
            halted     <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// Scoreboard bench for pc_sel_ctrl.
// Each cycle the stimulus pushes the expected output vector.
// A negedge monitor pops that vector and compares it with the DUT outputs.
module tb_pc_sel_ctrl;

    localparam int CAUSE_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall = 1'b0;
    logic [31:0]        pc_cur = 32'h0000_1000;
    logic               branch_taken = 1'b0;
    logic               jal = 1'b0;
    logic               jalr = 1'b0;
    logic               exc_req = 1'b0;
    logic [CAUSE_W-1:0] exc_cause = '0;
    logic               irq = 1'b0;
    logic               irq_en = 1'b0;
    logic               mret = 1'b0;
    logic [2:0]         Control_PC_Mux;
    logic [31:0]        mepc;
    logic [31:0]        mcause;
    logic               flush;
    logic               in_handler;
    logic               halted;

    pc_sel_ctrl #(.FLUSH_CYCLES(2), .CAUSE_W(CAUSE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pc_cur         (pc_cur),
        .branch_taken   (branch_taken),
        .jal            (jal),
        .jalr           (jalr),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .irq            (irq),
        .irq_en         (irq_en),
        .mret           (mret),
        .Control_PC_Mux (Control_PC_Mux),
        .mepc           (mepc),
        .mcause         (mcause),
        .flush          (flush),
        .in_handler     (in_handler),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic        flush;
        logic        inh;
        logic        halt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Advance to just after the next rising edge and clear one-shot requests.
    task automatic cyc();
        @(posedge clk);
        #1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jal          = 1'b0;
        jalr         = 1'b0;
        exc_req      = 1'b0;
        exc_cause    = '0;
        irq          = 1'b0;
        irq_en       = 1'b0;
        mret         = 1'b0;
    endtask

    task automatic ex(input string nm, input logic [2:0] s, input logic [31:0] e_mepc,
                      input logic [31:0] e_mcause, input logic fl, input logic ih,
                      input logic hl);
        exp_t e;
        e.sel    = s;
        e.mepc   = e_mepc;
        e.mcause = e_mcause;
        e.flush  = fl;
        e.inh    = ih;
        e.halt   = hl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the oldest expectation with the outputs at mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {Control_PC_Mux, mepc, mcause, flush, in_handler, halted};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got sel=%b mepc=%h mcause=%h flush=%b inh=%b halt=%b, want sel=%b mepc=%h mcause=%h flush=%b inh=%b halt=%b",
                         nm, a.sel, a.mepc, a.mcause, a.flush, a.inh, a.halt,
                         e.sel, e.mepc, e.mcause, e.flush, e.inh, e.halt);
            end
        end
    end

    initial begin
        // Reset and idle.
        cyc(); ex("reset", 3'b000, 32'h0, 32'h0, 0, 0, 0);
        cyc(); rst_n = 1'b1; ex("idle", 3'b000, 32'h0, 32'h0, 0, 0, 0);

        // Taken branch, then exactly two flush cycles.
        cyc(); branch_taken = 1; ex("br_sel", 3'b001, 32'h0, 32'h0, 0, 0, 0);
        cyc(); ex("br_fl1", 3'b000, 32'h0, 32'h0, 1, 0, 0);
        cyc(); ex("br_fl2", 3'b000, 32'h0, 32'h0, 1, 0, 0);
        cyc(); ex("br_run", 3'b000, 32'h0, 32'h0, 0, 0, 0);

        // Synchronous exception, masked irq inside the handler, then mret.
        cyc(); exc_req = 1; exc_cause = 5'd5; pc_cur = 32'h100;
        ex("exc_sel", 3'b101, 32'h0, 32'h0, 0, 0, 0);
        cyc(); ex("exc_fl1", 3'b000, 32'h100, 32'h5, 1, 1, 0);
        cyc(); ex("exc_fl2", 3'b000, 32'h100, 32'h5, 1, 1, 0);
        cyc(); ex("exc_run", 3'b000, 32'h100, 32'h5, 0, 1, 0);
        cyc(); irq = 1; irq_en = 1; pc_cur = 32'h200;
        ex("irq_masked", 3'b000, 32'h100, 32'h5, 0, 1, 0);
        cyc(); mret = 1; ex("mret_sel", 3'b111, 32'h100, 32'h5, 0, 1, 0);
        cyc(); ex("mret_fl1", 3'b000, 32'h100, 32'h5, 1, 0, 0);
        cyc(); ex("mret_fl2", 3'b000, 32'h100, 32'h5, 1, 0, 0);
        cyc(); ex("mret_run", 3'b000, 32'h100, 32'h5, 0, 0, 0);

        // Qualified interrupt; the level stays high but is masked afterwards.
        cyc(); irq = 1; irq_en = 1; pc_cur = 32'h200;
        ex("irq_sel", 3'b101, 32'h100, 32'h5, 0, 0, 0);
        cyc(); irq = 1; irq_en = 1;
        ex("irq_fl1", 3'b000, 32'h200, 32'h8000_000B, 1, 1, 0);
        cyc(); ex("irq_fl2", 3'b000, 32'h200, 32'h8000_000B, 1, 1, 0);
        cyc(); ex("irq_run", 3'b000, 32'h200, 32'h8000_000B, 0, 1, 0);
        cyc(); mret = 1; ex("irq_ret", 3'b111, 32'h200, 32'h8000_000B, 0, 1, 0);
        cyc(); ex("irq_ret_fl1", 3'b000, 32'h200, 32'h8000_000B, 1, 0, 0);
        cyc(); ex("irq_ret_fl2", 3'b000, 32'h200, 32'h8000_000B, 1, 0, 0);

        // exc_req, irq and jal together: the exception wins.
        cyc(); exc_req = 1; exc_cause = 5'd7; irq = 1; irq_en = 1; jal = 1; pc_cur = 32'h300;
        ex("prio_sel", 3'b101, 32'h200, 32'h8000_000B, 0, 0, 0);
        // Requests during FLUSH are ignored.
        cyc(); jal = 1; ex("jal_in_flush", 3'b000, 32'h300, 32'h7, 1, 1, 0);
        cyc(); exc_req = 1; exc_cause = 5'd3;
        ex("exc_in_flush", 3'b000, 32'h300, 32'h7, 1, 1, 0);
        cyc(); ex("prio_run", 3'b000, 32'h300, 32'h7, 0, 1, 0);
        cyc(); mret = 1; ex("prio_ret", 3'b111, 32'h300, 32'h7, 0, 1, 0);
        cyc(); ex("prio_ret_fl1", 3'b000, 32'h300, 32'h7, 1, 0, 0);
        cyc(); ex("prio_ret_fl2", 3'b000, 32'h300, 32'h7, 1, 0, 0);

        // Illegal mret traps with cause 2.
        cyc(); mret = 1; pc_cur = 32'h400;
        ex("ill_mret_sel", 3'b101, 32'h300, 32'h7, 0, 0, 0);
        cyc(); ex("ill_fl1", 3'b000, 32'h400, 32'h2, 1, 1, 0);
        cyc(); ex("ill_fl2", 3'b000, 32'h400, 32'h2, 1, 1, 0);
        cyc(); ex("ill_run", 3'b000, 32'h400, 32'h2, 0, 1, 0);

        // Double fault: HALT is sticky and mepc/mcause are kept.
        cyc(); exc_req = 1; exc_cause = 5'd4; pc_cur = 32'h500;
        ex("dbl_sel", 3'b000, 32'h400, 32'h2, 0, 1, 0);
        cyc(); jal = 1; ex("halt1", 3'b000, 32'h400, 32'h2, 1, 1, 1);
        cyc(); exc_req = 1; exc_cause = 5'd6;
        ex("halt2", 3'b000, 32'h400, 32'h2, 1, 1, 1);
        cyc(); rst_n = 1'b0; ex("rst_halt", 3'b000, 32'h0, 32'h0, 0, 0, 0);
        cyc(); rst_n = 1'b1; ex("rst_idle", 3'b000, 32'h0, 32'h0, 0, 0, 0);

        // A stalled jalr is held, then issued on release; stalls freeze the flush count.
        for (int i = 0; i < 3; i++) begin
            cyc(); stall = 1; jalr = 1; ex("stall_jalr", 3'b000, 32'h0, 32'h0, 0, 0, 0);
        end
        cyc(); jalr = 1; ex("jalr_sel", 3'b100, 32'h0, 32'h0, 0, 0, 0);
        cyc(); ex("jalr_fl1", 3'b000, 32'h0, 32'h0, 1, 0, 0);
        cyc(); stall = 1; ex("jalr_fl_stall", 3'b000, 32'h0, 32'h0, 1, 0, 0);
        cyc(); ex("jalr_fl2", 3'b000, 32'h0, 32'h0, 1, 0, 0);
        cyc(); ex("jalr_run", 3'b000, 32'h0, 32'h0, 0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
